// File: rtl/unit_sel_aug_add_if.sv
// Operand/result bundle for the mantissa alignment and ordering stage.
// The master drives operands and the slave returns the ordered, aligned pair.
interface unit_sel_aug_add_if #(
   parameter int unsigned MANT_W = 23,
   parameter int unsigned GRD_W  = 4
);
   localparam int unsigned EXT_W = 1 + MANT_W + GRD_W;

   logic              in_valid;
   logic [MANT_W-1:0] Mant_A;
   logic [MANT_W-1:0] Mant_B;
   logic [7:0]        E_sub;
   logic              Ce;
   logic              out_valid;
   logic [EXT_W-1:0]  Augend;
   logic [EXT_W-1:0]  Addend;
   logic              C_mant;

   modport master (
      output in_valid, Mant_A, Mant_B, E_sub, Ce,
      input  out_valid, Augend, Addend, C_mant
   );

   modport slave (
      input  in_valid, Mant_A, Mant_B, E_sub, Ce,
      output out_valid, Augend, Addend, C_mant
   );
endinterface

// File: rtl/unit_sel_aug_add.sv
// Aligns the smaller-exponent mantissa by E_sub and orders the pair so that
// Augend is the larger value; one registered output stage.
module unit_sel_aug_add #(
   parameter int unsigned MANT_W = 23,
   parameter int unsigned GRD_W  = 4
) (
   input logic                clk,
   input logic                rst_n,
   unit_sel_aug_add_if.slave  bus
);
   localparam int unsigned EXT_W = 1 + MANT_W + GRD_W;

   function automatic logic [EXT_W-1:0] extend_mant(input logic [MANT_W-1:0] m);
      return {1'b1, m, {GRD_W{1'b0}}};
   endfunction

   // Shifts of EXT_W or more flush every bit, so they saturate to zero.
   function automatic logic [EXT_W-1:0] shift_clamp(input logic [EXT_W-1:0] v,
                                                    input logic [7:0]       amt);
      logic [EXT_W-1:0] r;
      if (amt >= 8'(EXT_W)) begin
         r = {EXT_W{1'b0}};
      end else begin
         r = v >> amt;
      end
      return r;
   endfunction

   logic [EXT_W-1:0] m_a_s, m_b_s, m_em_s, m_el_s, m_sr_s;
   logic             sel_s;
   logic [EXT_W-1:0] augend_d, augend_q;
   logic [EXT_W-1:0] addend_d, addend_q;
   logic             c_mant_d, c_mant_q;
   logic             valid_q;

   // Operand extension, selection, alignment and ordering.
   always_comb begin
      m_a_s    = extend_mant(bus.Mant_A);
      m_b_s    = extend_mant(bus.Mant_B);
      m_em_s   = m_a_s;
      m_el_s   = m_b_s;
      augend_d = augend_q;
      addend_d = addend_q;
      c_mant_d = c_mant_q;
      if (bus.Ce) begin
         m_em_s = m_b_s;
         m_el_s = m_a_s;
      end else begin
         m_em_s = m_a_s;
         m_el_s = m_b_s;
      end
      m_sr_s = shift_clamp(m_el_s, bus.E_sub);
      sel_s  = (m_em_s > m_sr_s);
      // Ties fall to the shifted operand as Augend with C_mant cleared.
      if (bus.in_valid) begin
         if (sel_s) begin
            augend_d = m_em_s;
            addend_d = m_sr_s;
            c_mant_d = 1'b1;
         end else begin
            augend_d = m_sr_s;
            addend_d = m_em_s;
            c_mant_d = 1'b0;
         end
      end else begin
         augend_d = augend_q;
         addend_d = addend_q;
         c_mant_d = c_mant_q;
      end
   end

   // Output register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         augend_q <= {EXT_W{1'b0}};
         addend_q <= {EXT_W{1'b0}};
         c_mant_q <= 1'b0;
      end else begin
         valid_q  <= bus.in_valid;
         augend_q <= augend_d;
         addend_q <= addend_d;
         c_mant_q <= c_mant_d;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.Augend    = augend_q;
   assign bus.Addend    = addend_q;
   assign bus.C_mant    = c_mant_q;
endmodule

// File: tb/tb_unit_sel_aug_add.sv
// Scoreboard bench: the driver queues the expected result per clock edge,
// the monitor checks every edge (valid result, held value, or reset zeros).
module tb_unit_sel_aug_add;
   localparam int unsigned MANT_W = 23;
   localparam int unsigned GRD_W  = 4;
   localparam int unsigned EXT_W  = 1 + MANT_W + GRD_W;

   typedef struct {
      int unsigned      due;
      bit               rst;
      logic [EXT_W-1:0] aug;
      logic [EXT_W-1:0] add;
      logic             c;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sb[$];
   int unsigned drv_cyc = 0;
   int unsigned mon_cyc = 0;
   int n_checks = 0;
   int n_fail   = 0;
   logic [2*EXT_W:0] hold_v = '0;

   unit_sel_aug_add_if #(.MANT_W(MANT_W), .GRD_W(GRD_W)) bus ();

   unit_sel_aug_add #(.MANT_W(MANT_W), .GRD_W(GRD_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the extended mantissas.
   function automatic exp_t model(int unsigned a, int unsigned b, int unsigned e, bit ce);
      exp_t r;
      longint unsigned ma, mb, shifted, other, sr;
      int unsigned sh;
      ma      = (64'd1 << (MANT_W + GRD_W)) + longint'(a) * (64'd1 << GRD_W);
      mb      = (64'd1 << (MANT_W + GRD_W)) + longint'(b) * (64'd1 << GRD_W);
      sh      = (e > EXT_W) ? EXT_W : e;
      shifted = ce ? ma : mb;
      other   = ce ? mb : ma;
      sr      = shifted >> sh;
      r.due   = 0;
      r.rst   = 1'b0;
      if (other > sr) begin
         r.aug = other[EXT_W-1:0]; r.add = sr[EXT_W-1:0]; r.c = 1'b1;
      end else begin
         r.aug = sr[EXT_W-1:0]; r.add = other[EXT_W-1:0]; r.c = 1'b0;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [2*EXT_W+1:0] got,
                        input logic [2*EXT_W+1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got {v,aug,add,c}=%h expected %h", name, mon_cyc, got, exp);
      end
   endtask

   // One clock of stimulus; queues what the DUT must show after this edge.
   task automatic issue(input bit v, input bit rst, input int unsigned a, input int unsigned b,
                        input int unsigned e, input bit ce, input bit use_k,
                        input logic [EXT_W-1:0] kaug, input logic [EXT_W-1:0] kadd,
                        input logic kc);
      exp_t x;
      bus.in_valid = v;
      bus.Mant_A   = a[MANT_W-1:0];
      bus.Mant_B   = b[MANT_W-1:0];
      bus.E_sub    = e[7:0];
      bus.Ce       = ce;
      rst_n        = ~rst;
      @(posedge clk);
      drv_cyc++;
      if (rst) begin
         x.due = drv_cyc; x.rst = 1'b1; x.aug = '0; x.add = '0; x.c = 1'b0;
         sb.push_back(x);
      end else if (v) begin
         x = model(a, b, e, ce);
         if (use_k) begin
            x.aug = kaug; x.add = kadd; x.c = kc;
         end
         x.due = drv_cyc;
         sb.push_back(x);
      end
      #1;
   endtask

   task automatic rnd(input bit v, input int unsigned emax);
      int unsigned a, b;
      a = $urandom_range(0, (1 << MANT_W) - 1);
      b = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, (1 << MANT_W) - 1);
      issue(v, 1'b0, a, b, $urandom_range(0, emax), 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
   endtask

   // Monitor: every edge yields a valid result, a held value, or reset zeros.
   always @(negedge clk) begin
      exp_t x;
      logic [2*EXT_W+1:0] got;
      mon_cyc++;
      got = {bus.out_valid, bus.Augend, bus.Addend, bus.C_mant};
      if (sb.size() > 0 && sb[0].due == mon_cyc) begin
         x = sb.pop_front();
         if (x.rst) begin
            check("reset", got, '0);
            hold_v = '0;
         end else begin
            check("result", got, {1'b1, x.aug, x.add, x.c});
            hold_v = {x.aug, x.add, x.c};
         end
      end else begin
         check("hold", got, {1'b0, hold_v});
      end
   end

   initial begin
      issue(1'b1, 1'b1, 5, 6, 3, 1'b0, 1'b0, '0, '0, 1'b0);
      issue(1'b1, 1'b1, 7, 1, 0, 1'b1, 1'b0, '0, '0, 1'b0);
      issue(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 28'h8000000, 28'h8000000, 1'b0);
      issue(1'b1, 1'b0, 0, 0, 1, 1'b1, 1'b1, 28'h8000000, 28'h4000000, 1'b1);
      issue(1'b1, 1'b0, 32'h123456, 0, 28, 1'b0, 1'b1, 28'h9234560, 28'h0, 1'b1);
      issue(1'b1, 1'b0, 32'h123456, 0, 200, 1'b0, 1'b1, 28'h9234560, 28'h0, 1'b1);
      issue(1'b1, 1'b0, 0, 32'h7FFFFF, 0, 1'b0, 1'b1, 28'hFFFFFF0, 28'h8000000, 1'b0);
      issue(1'b1, 1'b0, 32'h7FFFFF, 32'h7FFFFF, 27, 1'b1, 1'b0, '0, '0, 1'b0);
      issue(1'b1, 1'b0, 32'h7FFFFF, 32'h7FFFFF, 255, 1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 3; i++) rnd(1'b0, 28);
      issue(1'b1, 1'b1, 32'h1, 32'h2, 0, 1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 120; i++) rnd(1'b1, 28);
      for (int i = 0; i < 40; i++) rnd(($urandom_range(0, 3) != 0), 255);
      issue(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
      issue(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected results left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
